operand_loader: RTL and testbench

- Upstream feeder for the operand datapath (top_design).
- Accepts operands serially, one 4-bit nibble per valid/ready handshake, and assembles NUM_OPS of them into one packed 24-bit operand word.
- Presents the word on a registered output with valid/ready handshake; the word drives the datapath's 24-bit inputs bus.
- Double-buffered: a staging register collects the next frame while the output register holds the current one.

---
 rtl/operand_loader.sv | 121 ++++++++++++
 tb/tb_operand_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// Serial operand loader: packs NUM_OPS nibbles into one word behind a double buffer.
// Optional partial-frame timeout is enabled by defining OPERAND_LOADER_TIMEOUT_EN.
module operand_loader #(
    parameter int OP_WIDTH       = 4,
    parameter int NUM_OPS        = 6,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [OP_WIDTH-1:0]          in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [OP_WIDTH*NUM_OPS-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   frame_count,
    output logic                         frame_err
);

    localparam int WORD_W = OP_WIDTH * NUM_OPS;
    localparam int CNT_W  = $clog2(NUM_OPS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_OPS);

    if (OP_WIDTH < 1 || NUM_OPS < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("operand_loader: illegal parameter values");
    end

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] staging_q, staging_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        frame_count_q, frame_count_d;
    logic              frame_err_q, frame_err_d;
    logic              accept;
    logic              transfer;

`ifdef OPERAND_LOADER_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               stalling;

    assign stalling = (cnt_q != '0) && (cnt_q < CNT_FULL) && !accept;
`endif

    // in_ready depends only on state so the upstream can never form a loop through it.
    assign in_ready = (cnt_q < CNT_FULL);
    assign accept   = in_valid && in_ready;
    assign transfer = (cnt_q == CNT_FULL) && (!out_valid_q || out_ready);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no branch can infer a latch.
        cnt_d         = cnt_q;
        staging_d     = staging_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        frame_count_d = frame_count_q;
        frame_err_d   = 1'b0;

        // A transfer in the same cycle as a consume keeps out_valid high: no bubble.
        if (transfer) begin
            out_data_d    = staging_q;
            out_valid_d   = 1'b1;
            cnt_d         = '0;
            frame_count_d = frame_count_q + 8'd1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // accept and transfer are exclusive: one needs cnt<NUM_OPS, the other cnt==NUM_OPS.
        if (accept) begin
            staging_d[int'(cnt_q)*OP_WIDTH +: OP_WIDTH] = in_data;
            cnt_d = cnt_q + CNT_W'(1);
        end

`ifdef OPERAND_LOADER_TIMEOUT_EN
        stall_d = stall_q;
        if (!stalling) begin
            stall_d = '0;
        end else if (stall_q == STALL_LAST) begin
            stall_d     = '0;
            cnt_d       = '0;
            staging_d   = '0;
            frame_err_d = 1'b1;
        end else begin
            stall_d = stall_q + STALL_W'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (reset) begin
            cnt_q         <= '0;
            staging_q     <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            frame_count_q <= 8'd0;
            frame_err_q   <= 1'b0;
`ifdef OPERAND_LOADER_TIMEOUT_EN
            stall_q       <= '0;
`endif
        end else begin
            cnt_q         <= cnt_d;
            staging_q     <= staging_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            frame_count_q <= frame_count_d;
            frame_err_q   <= frame_err_d;
`ifdef OPERAND_LOADER_TIMEOUT_EN
            stall_q       <= stall_d;
`endif
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign frame_count = frame_count_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: a nibble-list model predicts each packed word and its frame number.
module tb_operand_loader;

    localparam int NOPS = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  frame_count;
    logic        frame_err;

    typedef struct packed {
        logic [23:0] word;
        logic [7:0]  count;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] part_q[$];
    exp_t       mon_e;
    int         model_frames = 0;
    int         total = 0;
    int         bad = 0;
    int         err_pulses = 0;
    bit         rnd_ready = 1'b0;

    operand_loader dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_count (frame_count),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: collect nibbles; every NUM_OPS of them form word sum(n[k] * 16^k).
    task automatic model_push(input logic [3:0] v);
        logic [23:0] w;
        part_q.push_back(v);
        if (part_q.size() == NOPS) begin
            w = '0;
            for (int k = 0; k < NOPS; k++) w = w | (24'(part_q[k]) << (4 * k));
            model_frames++;
            exp_q.push_back('{word: w, count: 8'(model_frames)});
            part_q.delete();
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            in_data = 4'($urandom);
            step();
        end
    endtask

    task automatic send_nib(input logic [3:0] v, input bit gap);
        int budget;
        bit acc;
        if (gap) begin
            in_valid = 1'b0;
            in_data  = 4'($urandom);
            step();
        end
        in_valid = 1'b1;
        in_data  = v;
        budget   = 0;
        do begin
            acc = in_ready;
            step();
            budget++;
        end while (!acc && budget < 500);
        if (!acc) check("accept_timeout", {31'b0, acc}, 32'd1);
        else model_push(v);
    endtask

    task automatic send_frame(input logic [23:0] w, input bit gap);
        for (int k = 0; k < NOPS; k++) send_nib(w[4*k +: 4], gap);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        part_q.delete();
        exp_q.delete();
        model_frames = 0;
    endtask

    // Monitor: every accepted output word is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (frame_err) err_pulses++;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_out_data", 32'(out_data), 32'(mon_e.word));
                check("sb_frame_count", 32'(frame_count), 32'(mon_e.count));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int pulses0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b0;
        step();
        do_reset();

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);

        // Basic frame with continuous input.
        out_ready = 1'b1;
        send_frame(24'h153C26, 1'b0);
        in_valid = 1'b0;
        check("s1_in_ready_drop", 32'(in_ready), 32'd0);
        check("s1_valid_n1", 32'(out_valid), 32'd0);
        step();
        check("s1_in_ready_back", 32'(in_ready), 32'd1);
        check("s1_valid_n2", 32'(out_valid), 32'd1);
        check("s1_out_data", 32'(out_data), 32'h153C26);
        check("s1_frame_count", 32'(frame_count), 32'd1);
        idle(2);

        // Backpressure: frame B waits in staging while A is held.
        do_reset();
        out_ready = 1'b0;
        send_frame(24'h153C26, 1'b0);
        send_frame(24'h654321, 1'b0);
        idle(3);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_hold_data", 32'(out_data), 32'h153C26);
        check("bp_hold_count", 32'(frame_count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_no_bubble", 32'(out_valid), 32'd1);
        check("bp_new_data", 32'(out_data), 32'h654321);
        check("bp_new_count", 32'(frame_count), 32'd2);
        out_ready = 1'b1;
        idle(2);

        // Gappy input with garbage on idle cycles.
        send_frame(24'h153C26, 1'b1);
        idle(3);
        check("gap_out_data", 32'(out_data), 32'h153C26);

        // Reset with a pending output word and a partial frame.
        out_ready = 1'b0;
        send_frame(24'h111111, 1'b0);
        for (int k = 0; k < 3; k++) send_nib(4'($urandom), 1'b0);
        do_reset();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_count", 32'(frame_count), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        send_frame(24'hA0000F, 1'b0);
        idle(2);
        check("mid_rst_data", 32'(out_data), 32'hA0000F);
        check("mid_rst_frame_count", 32'(frame_count), 32'd1);

        // Partial frame followed by a long stall.
        pulses0 = err_pulses;
        send_nib(4'h6, 1'b0);
        send_nib(4'h2, 1'b0);
        idle(20);
`ifdef OPERAND_LOADER_TIMEOUT_EN
        check("to_err_pulses", 32'(err_pulses - pulses0), 32'd1);
        part_q.delete();
        send_frame(24'h153C26, 1'b0);
`else
        check("to_err_pulses", 32'(err_pulses - pulses0), 32'd0);
        send_nib(4'hC, 1'b0);
        send_nib(4'h3, 1'b0);
        send_nib(4'h5, 1'b0);
        send_nib(4'h1, 1'b0);
`endif
        idle(3);
        check("to_out_data", 32'(out_data), 32'h153C26);

        // Random frames, random gaps and random consumer backpressure.
        rnd_ready = 1'b1;
        repeat (40) begin
            send_frame(24'($urandom), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 3));
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check("rand_drain", 32'(exp_q.size()), 32'd0);

        // 256 frames wrap frame_count back to zero.
        do_reset();
        out_ready = 1'b1;
        repeat (256) send_frame(24'($urandom), 1'b0);
        idle(3);
        check("wrap_frame_count", 32'(frame_count), 32'd0);
        check("wrap_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
